// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the shared 16x8 data memory. It supports lock for read-modify-write sequences.
// Grants are round-robin by default. Define DATA_MEM_ARB_FIXED_PRIO_EN to make requester 0 win every conflict.
module data_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {OPEN, LOCK0, LOCK1} state_t;

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;

  logic [1:0]             valid, we, lock;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0]             grant;   // one-hot; a grant implies the requester is valid

  assign valid = {r1_valid, r0_valid};
  assign we    = {r1_we, r0_we};
  assign lock  = {r1_lock, r0_lock};
  assign addr  = {r1_addr, r0_addr};
  assign wdata = {r1_wdata, r0_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= OPEN;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = (|grant) ? grant[1] : last_grant_reg;
    unique case (state_reg)
      OPEN: begin
        if (grant[0] && lock[0])      state_next = LOCK0;
        else if (grant[1] && lock[1]) state_next = LOCK1;
      end
      LOCK0:   if (grant[0] && !lock[0]) state_next = OPEN;
      LOCK1:   if (grant[1] && !lock[1]) state_next = OPEN;
      default: state_next = OPEN;
    endcase
  end

  always_comb begin
    grant = 2'b00;
    unique case (state_reg)
      OPEN: begin
        if (valid == 2'b11) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
          grant = 2'b01;
`else
          grant = last_grant_reg ? 2'b01 : 2'b10;
`endif
        end else begin
          grant = valid;
        end
      end
      LOCK0:   grant[0] = valid[0];
      LOCK1:   grant[1] = valid[1];
      default: grant = 2'b00;
    endcase
  end

  assign r0_ready     = grant[0];
  assign r1_ready     = grant[1];
  assign mem_write_en = |(grant & we);

  always_comb begin
    mem_addr       = '0;
    mem_write_data = '0;
    if (grant[0]) begin
      mem_addr       = addr[0];
      mem_write_data = wdata[0];
    end else if (grant[1]) begin
      mem_addr       = addr[1];
      mem_write_data = wdata[1];
    end
  end

  // Per-requester read response: the data is captured at the accept edge and rvalid pulses for one cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic              rd_xfer;
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    assign rd_xfer = grant[gi] & ~we[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= rd_xfer;
        if (rd_xfer) rdata_reg <= mem_read_data;
      end
    end
  end

  assign r0_rvalid = g_resp[0].rvalid_reg;
  assign r0_rdata  = g_resp[0].rdata_reg;
  assign r1_rvalid = g_resp[1].rvalid_reg;
  assign r1_rdata  = g_resp[1].rdata_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 16x8 memory (sync write, async read).
// Memory word i starts at i*0x11. Inputs change 1ns after a rising edge, and outputs are checked 1ns later.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_valid, r0_we, r0_lock, r0_ready, r0_rvalid;
  logic [3:0] r0_addr;
  logic [7:0] r0_wdata, r0_rdata;
  logic       r1_valid, r1_we, r1_lock, r1_ready, r1_rvalid;
  logic [3:0] r1_addr;
  logic [7:0] r1_wdata, r1_rdata;
  logic       mem_write_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_write_data, mem_read_data;

  logic [7:0] mem [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                           8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_g1;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr];
  always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_write_data;

  data_mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int n, input logic v, input logic w, input logic l,
                     input logic [3:0] a, input logic [7:0] d);
    if (n == 0) begin
      r0_valid = v; r0_we = w; r0_lock = l; r0_addr = a; r0_wdata = d;
    end else begin
      r1_valid = v; r1_we = w; r1_lock = l; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 4'h0, 8'h00);
    drv(1, 0, 0, 0, 4'h0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("reset_r0_rvalid", r0_rvalid, 0);
    chk("reset_r1_rvalid", r1_rvalid, 0);
    chk("reset_r0_rdata", r0_rdata, 0);
    chk("reset_r1_rdata", r1_rdata, 0);
    chk("reset_ready", {r1_ready, r0_ready}, 0);
    chk("reset_mem_we", mem_write_en, 0);
    cyc();
    rst_n = 1'b1;

    // Write, then read back on the next cycle.
    drv(0, 1, 1, 0, 4'h3, 8'hA5);
    #1;
    chk("wr_r0_ready", r0_ready, 1);
    chk("wr_mem_we", mem_write_en, 1);
    chk("wr_mem_addr", mem_addr, 3);
    chk("wr_mem_wdata", mem_write_data, 8'hA5);
    $display("txn: r0 write addr=3 data=a5");
    cyc();
    chk("wr_no_rvalid", r0_rvalid, 0);
    drv(0, 1, 0, 0, 4'h3, 8'h00);
    #1;
    chk("rd_r0_ready", r0_ready, 1);
    chk("rd_mem_we", mem_write_en, 0);
    cyc();
    drv(0, 0, 0, 0, 4'h0, 8'h00);
    chk("rd_r0_rvalid", r0_rvalid, 1);
    chk("rd_r0_rdata", r0_rdata, 8'hA5);
    $display("txn: r0 read addr=3 -> %02h", r0_rdata);
    cyc();
    chk("rd_rvalid_pulse", r0_rvalid, 0);
    chk("rd_rdata_hold", r0_rdata, 8'hA5);

    // Contention after a fresh reset: round-robin gives 0,1,0,1. Fixed priority always gives 0.
    do_reset();
    drv(0, 1, 0, 0, 4'h1, 8'h00);
    drv(1, 1, 0, 0, 4'h2, 8'h00);
    for (int i = 0; i < 4; i++) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      exp_g1 = 1'b0;
`else
      exp_g1 = (i % 2 == 1);
`endif
      #1;
      chk("cont_r0_ready", r0_ready, !exp_g1);
      chk("cont_r1_ready", r1_ready, exp_g1);
      chk("cont_mem_addr", mem_addr, exp_g1 ? 2 : 1);
      cyc();
      chk("cont_r0_rvalid", r0_rvalid, !exp_g1);
      chk("cont_r1_rvalid", r1_rvalid, exp_g1);
      chk("cont_rdata", exp_g1 ? r1_rdata : r0_rdata, exp_g1 ? 8'h22 : 8'h11);
      $display("txn: contention cycle %0d granted r%0d", i, exp_g1);
    end
    drv(0, 0, 0, 0, 4'h0, 8'h00);
    drv(1, 0, 0, 0, 4'h0, 8'h00);
    cyc();

    // Requester 1 locks the memory. Requester 0 stays blocked until the unlocking write.
    drv(1, 1, 0, 1, 4'h5, 8'h00);
    #1;
    chk("lk_r1_ready", r1_ready, 1);
    cyc();
    chk("lk_r1_rvalid", r1_rvalid, 1);
    chk("lk_r1_rdata", r1_rdata, 8'h55);
    $display("txn: r1 locked read addr=5 -> %02h", r1_rdata);
    drv(1, 0, 0, 0, 4'h0, 8'h00);
    drv(0, 1, 0, 0, 4'h5, 8'h00);
    #1;
    chk("lk_r0_blocked", r0_ready, 0);
    chk("lk_idle_addr", mem_addr, 0);
    cyc();
    drv(1, 1, 1, 0, 4'h5, 8'h3C);
    #1;
    chk("lk_r0_blocked2", r0_ready, 0);
    chk("lk_r1_wr_ready", r1_ready, 1);
    chk("lk_wr_mem_we", mem_write_en, 1);
    chk("lk_wr_mem_addr", mem_addr, 5);
    cyc();
    $display("txn: r1 unlock write addr=5 data=3c");
    drv(1, 0, 0, 0, 4'h0, 8'h00);
    chk("lk_mem5", mem[5], 8'h3C);
    #1;
    chk("unlk_r0_ready", r0_ready, 1);
    chk("unlk_mem_addr", mem_addr, 5);
    cyc();
    drv(0, 0, 0, 0, 4'h0, 8'h00);
    chk("unlk_r0_rvalid", r0_rvalid, 1);
    chk("unlk_r0_rdata", r0_rdata, 8'h3C);
    $display("txn: r0 read addr=5 -> %02h", r0_rdata);
    cyc();

    // Reset asserted while LOCK1 is held and a response is pending.
    drv(1, 1, 0, 1, 4'h7, 8'h00);
    #1;
    chk("rl_r1_ready", r1_ready, 1);
    cyc();
    chk("rl_r1_rvalid_pending", r1_rvalid, 1);
    drv(1, 0, 0, 0, 4'h0, 8'h00);
    drv(0, 1, 0, 0, 4'h4, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("rl_r1_rvalid_cleared", r1_rvalid, 0);
    chk("rl_r1_rdata_cleared", r1_rdata, 0);
    chk("rl_r0_ready_open", r0_ready, 1);
    $display("txn: reset during LOCK1");
    drv(0, 0, 0, 0, 4'h0, 8'h00);
    cyc();
    rst_n = 1'b1;

    // Idle for three cycles.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_mem_we", mem_write_en, 0);
      chk("idle_ready", {r1_ready, r0_ready}, 0);
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_rvalid", {r1_rvalid, r0_rvalid}, 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
